// File: rtl/regfile_master_pkg.sv
// Shared types and helpers for the register-file bus initiator.
// Op codes, FSM states and the read-modify-write bit merge.
package regfile_master_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_RMW   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  // Widest data path the merge helper supports; callers zero-extend into it.
  localparam int unsigned MERGE_W = 64;

  function automatic logic [MERGE_W-1:0] rmw_merge(
    input logic [MERGE_W-1:0] old_val,
    input logic [MERGE_W-1:0] data_val,
    input logic [MERGE_W-1:0] mask_val
  );
    return (old_val & ~mask_val) | (data_val & mask_val);
  endfunction

endpackage

// File: rtl/regfile_master.sv
// Bus initiator sequencing READ / WRITE / RMW commands onto a byte-enabled
// register-file slave port; all outputs are registered.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready for a command; rf_addr_o holds last address
// ST_RD   | address driven, counting down read latency, then sampling
// ST_WR   | one-cycle write strobe (plain write or merged RMW value)
// ST_RSP  | read data presented until the consumer takes it
module regfile_master
  import regfile_master_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BE_W   = (DATA_W + 7) / 8,
  parameter int unsigned RD_LAT = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic [DATA_W-1:0] cmd_mask_i,
  input  logic [BE_W-1:0]   cmd_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0] rf_data_o,
  output logic              rf_wren_o,
  output logic [BE_W-1:0]   rf_be_o,
  input  logic [DATA_W-1:0] rf_data_i
);

  localparam int unsigned CNT_W = 2;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic              rf_wren_q, rf_wren_d;
  logic [BE_W-1:0]   rf_be_q, rf_be_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              err_q, err_d;

  op_e               cmd_op;
  logic              accept;
  logic              rd_done;
  logic [DATA_W-1:0] merged;

  assign cmd_op  = op_e'(cmd_op_i);
  assign accept  = cmd_valid_i & cmd_ready_q;
  assign rd_done = (state_q == ST_RD) && (cnt_q == '0);
  assign merged  = DATA_W'(rmw_merge(MERGE_W'(rf_data_i), MERGE_W'(data_q), MERGE_W'(mask_q)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      data_q      <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      rf_wren_q   <= 1'b0;
      rf_be_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
      rf_wren_q   <= rf_wren_d;
      rf_be_q     <= rf_be_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (cmd_op)
            OP_WRITE:        state_d = ST_WR;
            OP_READ, OP_RMW: state_d = ST_RD;
            default:         state_d = ST_IDLE;
          endcase
        end
      end
      ST_RD: begin
        if (rd_done) begin
          state_d = (op_q == OP_RMW) ? ST_WR : ST_RSP;
        end
      end
      ST_WR: begin
        state_d = (op_q == OP_RMW) ? ST_RSP : ST_IDLE;
      end
      ST_RSP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so their next values follow state_d.
  always_comb begin
    op_d       = op_q;
    data_d     = data_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    rf_be_d    = rf_be_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;

    if (accept) begin
      if (cmd_op == OP_RSVD) begin
        err_d = 1'b1;
      end else begin
        op_d      = cmd_op;
        data_d    = cmd_data_i;
        mask_d    = cmd_mask_i;
        rf_addr_d = cmd_addr_i;
        cnt_d     = CNT_W'(RD_LAT);
        if (cmd_op == OP_WRITE) begin
          rf_data_d = cmd_data_i;
          rf_be_d   = cmd_be_i;
        end
      end
    end

    if (state_q == ST_RD) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        rsp_data_d = rf_data_i;
        if (op_q == OP_RMW) begin
          rf_data_d = merged;
          rf_be_d   = '1;
        end
      end
    end

    rf_wren_d   = (state_d == ST_WR);
    rsp_valid_d = (state_d == ST_RSP);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign err_o       = err_q;
  assign rf_addr_o   = rf_addr_q;
  assign rf_data_o   = rf_data_q;
  assign rf_wren_o   = rf_wren_q;
  assign rf_be_o     = rf_be_q;

endmodule

// File: tb/tb_regfile_master.sv
// Bench for regfile_master: directed vector table, multi-cycle corner sequences
// and a randomized run against a behavioural register-file model.
module tb_regfile_master;

  localparam int AW = 7;
  localparam int DW = 16;
  localparam int BW = 2;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // DUT0: RD_LAT = 0
  logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready, err, rf_wren;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr, rf_addr;
  logic [DW-1:0] cmd_data, cmd_mask, rsp_data, rf_wdata, rf_rdata;
  logic [BW-1:0] cmd_be, rf_be;

  // DUT1: RD_LAT = 2
  logic          b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready, b_err, b_rf_wren;
  logic [1:0]    b_cmd_op;
  logic [AW-1:0] b_cmd_addr, b_rf_addr;
  logic [DW-1:0] b_cmd_data, b_cmd_mask, b_rsp_data, b_rf_wdata, b_rf_rdata;
  logic [BW-1:0] b_cmd_be, b_rf_be;

  regfile_master #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .RD_LAT(0)) u_dut0 (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_mask_i(cmd_mask), .cmd_be_i(cmd_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .err_o(err),
    .rf_addr_o(rf_addr), .rf_data_o(rf_wdata), .rf_wren_o(rf_wren), .rf_be_o(rf_be),
    .rf_data_i(rf_rdata)
  );

  regfile_master #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .RD_LAT(2)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_cmd_ready), .cmd_op_i(b_cmd_op),
    .cmd_addr_i(b_cmd_addr), .cmd_data_i(b_cmd_data), .cmd_mask_i(b_cmd_mask), .cmd_be_i(b_cmd_be),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_data_o(b_rsp_data), .err_o(b_err),
    .rf_addr_o(b_rf_addr), .rf_data_o(b_rf_wdata), .rf_wren_o(b_rf_wren), .rf_be_o(b_rf_be),
    .rf_data_i(b_rf_rdata)
  );

  // Register-file slaves: addr[6]=0 selects ctrl, addr[6]=1 selects status.
  logic [DW-1:0] ctrl0 [64] = '{default: 16'h0000};
  logic [DW-1:0] sreg0 [64];
  logic [DW-1:0] sreg1 [64];
  int            wr_cnt0 = 0;
  logic [BW-1:0] last_be0 = '0;

  assign rf_rdata   = rf_addr[6] ? sreg0[rf_addr[5:0]] : ctrl0[rf_addr[5:0]];
  assign b_rf_rdata = b_rf_addr[6] ? sreg1[b_rf_addr[5:0]] : 16'h0000;

  always @(posedge clk_i) begin
    if (rf_wren) begin
      wr_cnt0  <= wr_cnt0 + 1;
      last_be0 <= rf_be;
      if (!rf_addr[6]) begin
        for (int b = 0; b < BW; b++) begin
          if (rf_be[b]) ctrl0[rf_addr[5:0]][8*b +: 8] <= rf_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command on DUT0 and observe it until the master is idle again.
  task automatic do_cmd(
    input  logic [1:0]    op,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    input  logic [DW-1:0] mask,
    input  logic [BW-1:0] be,
    input  int            delay,
    output logic          got,
    output logic [DW-1:0] rdata,
    output int            nwr,
    output logic [BW-1:0] wbe,
    output int            cyc,
    output logic          stable,
    output logic          ready_low
  );
    int w0, wait_n, guard;
    got = 1'b0; rdata = '0; nwr = 0; wbe = '0; cyc = 0; stable = 1'b1; ready_low = 1'b1;
    w0 = wr_cnt0;
    guard = 0;
    @(negedge clk_i);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask; cmd_be = be;
    @(posedge clk_i);
    cyc = 1;
    @(negedge clk_i);
    cmd_valid = 1'b0;
    wait_n = 0;
    guard = 0;
    while (guard < 50) begin
      if (rsp_valid) begin
        if (!got) rdata = rsp_data;
        else if (rsp_data !== rdata) stable = 1'b0;
        got = 1'b1;
        if (cmd_ready) ready_low = 1'b0;
        if (wait_n >= delay) rsp_ready = 1'b1;
        else wait_n++;
      end else if (cmd_ready) begin
        break;
      end
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
      guard++;
    end
    rsp_ready = 1'b0;
    if (guard >= 50) chk("cmd_timeout", 32'(guard), 32'd0);
    nwr = wr_cnt0 - w0;
    wbe = last_be0;
  endtask

  typedef struct {
    string         name;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
    logic [BW-1:0] be;
    int            delay;
    logic          exp_rsp;
    logic [DW-1:0] exp_data;
    int            exp_wr;
    logic [BW-1:0] exp_be;
    logic [5:0]    mem_idx;
    logic [DW-1:0] exp_mem;
    int            exp_cyc;
  } vec_t;

  vec_t          vecs [6];
  logic [DW-1:0] ref_mem [64];

  logic          got, stable, ready_low;
  logic [DW-1:0] rdata;
  int            nwr, cyc, guard;
  logic [BW-1:0] wbe;

  initial begin
    rst_i = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0; cmd_be = '0;
    rsp_ready = 1'b0;
    b_cmd_valid = 1'b0; b_cmd_op = '0; b_cmd_addr = '0; b_cmd_data = '0; b_cmd_mask = '0; b_cmd_be = '0;
    b_rsp_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      sreg0[i] = 16'hB000 + 16'(i);
      sreg1[i] = 16'h0000;
      ref_mem[i] = 16'h0000;
    end

    //                name         op    addr   data      mask      be     dly rsp  exp_data  wr be     idx    mem      cyc
    vecs[0] = '{"wr_be01",   2'd1, 7'h05, 16'hA5C3, 16'h0000, 2'b01, 0, 1'b0, 16'h0000, 1, 2'b01, 6'h05, 16'h00C3, 2};
    vecs[1] = '{"rd_stall",  2'd0, 7'h05, 16'h0000, 16'h0000, 2'b00, 3, 1'b1, 16'h00C3, 0, 2'b00, 6'h05, 16'h00C3, 6};
    vecs[2] = '{"rmw",       2'd2, 7'h05, 16'hFF00, 16'h0F00, 2'b00, 0, 1'b1, 16'h00C3, 1, 2'b11, 6'h05, 16'h0FC3, 4};
    vecs[3] = '{"wr_be10",   2'd1, 7'h10, 16'h1234, 16'h0000, 2'b10, 0, 1'b0, 16'h0000, 1, 2'b10, 6'h10, 16'h1200, 2};
    vecs[4] = '{"rd_stat",   2'd0, 7'h41, 16'h0000, 16'h0000, 2'b00, 0, 1'b1, 16'hB001, 0, 2'b00, 6'h10, 16'h1200, 3};
    vecs[5] = '{"rmw_stall", 2'd2, 7'h10, 16'h00FF, 16'h00F0, 2'b00, 1, 1'b1, 16'h1200, 1, 2'b11, 6'h10, 16'h12F0, 5};

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_outputs", 32'({cmd_ready, rsp_valid, rsp_data, err, rf_addr, rf_wren, rf_be}), 32'd0);
    chk("reset_wdata", 32'(rf_wdata), 32'd0);
    rst_i = 1'b0;

    for (int v = 0; v < 6; v++) begin
      do_cmd(vecs[v].op, vecs[v].addr, vecs[v].data, vecs[v].mask, vecs[v].be, vecs[v].delay,
             got, rdata, nwr, wbe, cyc, stable, ready_low);
      chk({vecs[v].name, "_rsp"}, 32'(got), 32'(vecs[v].exp_rsp));
      if (vecs[v].exp_rsp) begin
        chk({vecs[v].name, "_data"}, 32'(rdata), 32'(vecs[v].exp_data));
        chk({vecs[v].name, "_stable"}, 32'(stable), 32'd1);
        chk({vecs[v].name, "_ready_low"}, 32'(ready_low), 32'd1);
      end
      chk({vecs[v].name, "_writes"}, 32'(nwr), 32'(vecs[v].exp_wr));
      if (vecs[v].exp_wr != 0) chk({vecs[v].name, "_be"}, 32'(wbe), 32'(vecs[v].exp_be));
      chk({vecs[v].name, "_mem"}, 32'(ctrl0[vecs[v].mem_idx]), 32'(vecs[v].exp_mem));
      chk({vecs[v].name, "_cycles"}, 32'(cyc), 32'(vecs[v].exp_cyc));
    end

    // RD_LAT=2: status value changes each cycle; only the third-cycle value may be captured.
    sreg1[1] = 16'h5555;
    guard = 0;
    @(negedge clk_i);
    while (!b_cmd_ready && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    chk("lat2_ready", 32'(b_cmd_ready), 32'd1);
    b_cmd_valid = 1'b1; b_cmd_op = 2'd0; b_cmd_addr = 7'h41;
    @(posedge clk_i);
    @(negedge clk_i);
    b_cmd_valid = 1'b0;
    sreg1[1] = 16'hAAAA;
    @(negedge clk_i);
    chk("lat2_no_rsp_c1", 32'(b_rsp_valid), 32'd0);
    sreg1[1] = 16'h1111;
    @(negedge clk_i);
    chk("lat2_no_rsp_c2", 32'(b_rsp_valid), 32'd0);
    sreg1[1] = 16'h1234;
    @(negedge clk_i);
    sreg1[1] = 16'h5555;
    chk("lat2_rsp_valid", 32'(b_rsp_valid), 32'd1);
    chk("lat2_rsp_data", 32'(b_rsp_data), 32'h1234);
    chk("lat2_no_write", 32'(b_rf_wren), 32'd0);
    b_rsp_ready = 1'b1;
    @(negedge clk_i);
    b_rsp_ready = 1'b0;
    chk("lat2_idle", 32'({b_cmd_ready, b_rsp_valid}), 32'b10);

    // Reset during the read phase of an RMW must abort it without a write.
    begin
      int w0;
      w0 = wr_cnt0;
      @(negedge clk_i);
      cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 7'h05; cmd_data = 16'hFFFF; cmd_mask = 16'hFFFF;
      @(posedge clk_i);
      @(negedge clk_i);
      cmd_valid = 1'b0;
      chk("abort_in_rd", 32'({rf_wren, rf_addr}), 32'h05);
      rst_i = 1'b1;
      #1;
      chk("abort_outputs", 32'({cmd_ready, rsp_valid, rsp_data, err, rf_addr, rf_wren, rf_be}), 32'd0);
      chk("abort_wdata", 32'(rf_wdata), 32'd0);
      repeat (3) begin
        @(negedge clk_i);
        chk("abort_wren", 32'(rf_wren), 32'd0);
      end
      rst_i = 1'b0;
      chk("abort_writes", 32'(wr_cnt0 - w0), 32'd0);
      chk("abort_mem", 32'(ctrl0[5]), 32'h0FC3);
    end
    do_cmd(2'd0, 7'h05, 16'h0, 16'h0, 2'b00, 0, got, rdata, nwr, wbe, cyc, stable, ready_low);
    chk("post_rst_rsp", 32'(got), 32'd1);
    chk("post_rst_data", 32'(rdata), 32'h0FC3);
    chk("post_rst_cycles", 32'(cyc), 32'd3);

    // Reserved op: accepted immediately, no bus activity, sticky error.
    do_cmd(2'd3, 7'h10, 16'hDEAD, 16'hFFFF, 2'b11, 0, got, rdata, nwr, wbe, cyc, stable, ready_low);
    chk("rsvd_rsp", 32'(got), 32'd0);
    chk("rsvd_writes", 32'(nwr), 32'd0);
    chk("rsvd_cycles", 32'(cyc), 32'd1);
    chk("rsvd_err", 32'(err), 32'd1);
    chk("rsvd_mem", 32'(ctrl0[6'h10]), 32'h12F0);

    // Randomized traffic on the untouched upper ctrl half against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]    op;
      logic [AW-1:0] addr;
      logic [DW-1:0] data, mask, old, nxt;
      logic [BW-1:0] be;
      int            dly, exp_cyc;
      op   = 2'($urandom_range(0, 2));
      addr = 7'h20 + 7'($urandom_range(0, 31));
      data = 16'($urandom);
      mask = 16'($urandom);
      be   = 2'($urandom_range(0, 3));
      dly  = $urandom_range(0, 2);
      old  = ref_mem[addr[5:0]];
      nxt  = old;
      if (op == 2'd1) begin
        for (int b = 0; b < BW; b++) if (be[b]) nxt[8*b +: 8] = data[8*b +: 8];
        exp_cyc = 2;
      end else if (op == 2'd2) begin
        for (int i = 0; i < DW; i++) nxt[i] = mask[i] ? data[i] : old[i];
        exp_cyc = 4 + dly;
      end else begin
        exp_cyc = 3 + dly;
      end
      ref_mem[addr[5:0]] = nxt;
      do_cmd(op, addr, data, mask, be, dly, got, rdata, nwr, wbe, cyc, stable, ready_low);
      chk($sformatf("rnd%0d_rsp", n), 32'(got), 32'(op != 2'd1));
      if (op != 2'd1) chk($sformatf("rnd%0d_data", n), 32'(rdata), 32'(old));
      chk($sformatf("rnd%0d_writes", n), 32'(nwr), 32'(op != 2'd0));
      chk($sformatf("rnd%0d_cycles", n), 32'(cyc), 32'(exp_cyc));
    end
    for (int i = 32; i < 64; i++) begin
      chk($sformatf("rnd_mem_%0d", i), 32'(ctrl0[i]), 32'(ref_mem[i]));
    end
    chk("err_sticky", 32'(err), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
